// File: rtl/ttt_pkg.sv
// Shared definitions for the turn controller.
// Holds the 2-bit cell codes, the result codes reported on `result`, and the
// FSM state encoding. The state encoding is also exposed on the top-level
// debug port.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    X_WIN = 2'b01,
    O_WIN = 2'b10,
    DRAW  = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    X_TURN = 2'b00,
    O_TURN = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam int         NUM_CELLS = 16;
  localparam logic [4:0] MAX_MOVES = 5'd16;

endpackage

// File: rtl/turn_controller_if.sv
// Signal bundle between the game environment and the turn controller.
//
// Request semantics: play and pc are level requests, sampled on every rising
// clock edge. There is no ready/ack. A request is either accepted, which
// means the board is written at that edge, or rejected, which means
// illegal_move pulses for one cycle. A request from the side that is not on
// turn, or any request while the game is over, is dropped silently. The
// requester sees the outcome on the cycle after the edge.
//
//   master : drives new_game, play, player_pos, pc, pc_pos, winner
//            and observes the game status
//   slave  : the controller (drives board, turn, game_over, result,
//            illegal_move, move_count)
interface turn_controller_if;
  import ttt_pkg::*;

  logic        new_game;
  logic        play;
  logic [3:0]  player_pos;
  logic        pc;
  logic [3:0]  pc_pos;
  logic [1:0]  winner;

  logic [31:0] board;
  logic        turn;
  logic        game_over;
  logic [1:0]  result;
  logic        illegal_move;
  logic [4:0]  move_count;

  modport master (
    output new_game, play, player_pos, pc, pc_pos, winner,
    input  board, turn, game_over, result, illegal_move, move_count
  );

  modport slave (
    input  new_game, play, player_pos, pc, pc_pos, winner,
    output board, turn, game_over, result, illegal_move, move_count
  );

endinterface

// File: rtl/nospace_detector.sv
// Full-board detector.
// Ports:
//   cells    : the 16 registered board cells, 2 bits each
//   no_space : high when every cell is non-empty
module nospace_detector
  import ttt_pkg::*;
(
  input  logic [15:0][1:0] cells,
  output logic             no_space
);

  always_comb begin
    no_space = 1'b1;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (cells[k] == EMPTY) no_space = 1'b0;
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Tic-tac-toe style turn controller on a 16-cell board.
// It alternates between X (player) and O (computer). It writes accepted moves
// into a registered board, rejects moves onto occupied cells, and ends the
// game on a reported win or on a full board.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus            : request/status bundle (turn_controller_if.slave)
//   state_dbg      : current FSM state (ttt_pkg::state_t encoding)
// Parameter:
//   FIRST_PLAYER   : side on turn after reset/new_game (0 = X, 1 = O)
module turn_controller
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
)(
  input  logic                    clock,
  input  logic                    reset_n,
  turn_controller_if.slave        bus,
  output logic [1:0]              state_dbg
);

  localparam state_t FIRST_STATE = FIRST_PLAYER ? O_TURN : X_TURN;

  state_t      state_q, state_d;
  logic [31:0] board_q, board_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  result_q, result_d;
  logic        illegal_q, illegal_d;

  logic        no_space;
  logic [1:0]  winner_eff;
  logic        move_x, move_o;
  logic [3:0]  move_pos;
  logic [4:0]  move_lsb;

  // The detector looks at the registered board, so a full board is only
  // seen on the cycle after the last write.
  nospace_detector u_nospace (
    .cells    (board_q),
    .no_space (no_space)
  );

  // Winner code 11 is meaningless and is treated as "no winner".
  assign winner_eff = (bus.winner == 2'b11) ? 2'b00 : bus.winner;

  // Only the request belonging to the side on turn can act. The other side's
  // request is dropped without flagging an illegal move.
  assign move_x   = (state_q == X_TURN) && bus.play;
  assign move_o   = (state_q == O_TURN) && bus.pc;
  assign move_pos = move_o ? bus.pc_pos : bus.player_pos;
  assign move_lsb = {move_pos, 1'b0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FIRST_STATE;
      board_q   <= '0;
      count_q   <= '0;
      result_q  <= NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      count_q   <= count_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  // Priority: new_game, then completion check, then the move request.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    count_d   = count_q;
    result_d  = result_q;
    illegal_d = 1'b0;

    if (bus.new_game) begin
      state_d  = FIRST_STATE;
      board_d  = '0;
      count_d  = '0;
      result_d = NONE;
    end else if (state_q != DONE) begin
      if (winner_eff != 2'b00) begin
        // A reported win beats a simultaneously full board.
        state_d  = DONE;
        result_d = winner_eff;
      end else if (no_space) begin
        state_d  = DONE;
        result_d = DRAW;
      end else if (move_x || move_o) begin
        if (board_q[move_lsb +: 2] == EMPTY) begin
          board_d[move_lsb +: 2] = move_x ? X : O;
          if (count_q != MAX_MOVES) count_d = count_q + 5'd1;
          state_d = move_x ? O_TURN : X_TURN;
        end else begin
          illegal_d = 1'b1;
        end
      end
    end
  end

  assign bus.board        = board_q;
  assign bus.turn         = (state_q == O_TURN);
  assign bus.game_over    = (state_q == DONE);
  assign bus.result       = result_q;
  assign bus.illegal_move = illegal_q;
  assign bus.move_count   = count_q;
  assign state_dbg        = state_q;

endmodule
